// File: rtl/mm_arb_pkg.sv
// Shared types and defaults for the Montgomery multiplier arbiter.
//   state_t         : arbiter FSM state (S_IDLE, S_BUSY)
//   W_DEFAULT       : default operand/result width
//   TIMEOUT_DEFAULT : default watchdog limit in cycles (MM_ARB_TIMEOUT_EN builds)
package mm_arb_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam int unsigned W_DEFAULT       = 255;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority picker. Returns the first set bit of req at or
// after ptr, wrapping modulo N_REQ.
//   req   : request vector
//   ptr   : search start position (must be < N_REQ)
//   grant : one-hot winner, all zero when req is zero
//   idx   : binary index of the winner, 0 when req is zero
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one Montgomery multiplier core
// between N_REQ requesters. One multiplication is in flight at a time; operands
// are captured at grant and held until completion.
// Optional feature macro: MM_ARB_TIMEOUT_EN adds a watchdog (TIMEOUT_CYC) and the
// o_err port; without it the arbiter waits indefinitely for the core.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_req               : level request per requester
//   i_a, i_b            : packed operands, requester k at [k*W +: W]
//   o_grant             : one-hot owner of the in-flight operation
//   o_done              : one-cycle completion pulse to the owner
//   o_result            : registered result, held until the next completion
//   o_busy              : operation in flight
//   o_mm_start          : one-cycle start pulse to the core
//   o_mm_a, o_mm_b      : registered operands to the core
//   i_mm_result         : core result
//   i_mm_finished       : core completion pulse
//   o_err               : watchdog expiry pulse (MM_ARB_TIMEOUT_EN only)
module mm_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = W_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_a,
  input  logic [N_REQ*W-1:0] i_b,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_done,
  output logic [W-1:0]       o_result,
  output logic               o_busy,
  output logic               o_mm_start,
  output logic [W-1:0]       o_mm_a,
  output logic [W-1:0]       o_mm_b,
`ifdef MM_ARB_TIMEOUT_EN
  output logic               o_err,
`endif
  input  logic [W-1:0]       i_mm_result,
  input  logic               i_mm_finished
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mm_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [W-1:0]       result_q, result_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;

  logic [N_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [W-1:0]       pick_a, pick_b;

`ifdef MM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;

  // Counter is 0 in the start cycle, so expiry is seen TIMEOUT_CYC cycles later.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC));
`endif

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (i_req),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  // One-hot driven operand select from the winner's slice.
  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_grant[k]) begin
        pick_a = i_a[k*W +: W];
        pick_b = i_b[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    result_d = result_q;
    busy_d   = busy_q;
    start_d  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
`ifdef MM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A stray i_mm_finished here is ignored by construction.
        if (|i_req) begin
          grant_d = pick_grant;
          a_d     = pick_a;
          b_d     = pick_b;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_BUSY;
          ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
`ifdef MM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_BUSY: begin
        if (i_mm_finished) begin
          result_d = i_mm_result;
          done_d   = grant_q;
          grant_d  = '0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
`ifdef MM_ARB_TIMEOUT_EN
        else if (timeout) begin
          result_d = '0;
          done_d   = grant_q;
          err_d    = 1'b1;
          grant_d  = '0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
`ifdef MM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifdef MM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign o_grant    = grant_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_busy     = busy_q;
  assign o_mm_start = start_q;
  assign o_mm_a     = a_q;
  assign o_mm_b     = b_q;
`ifdef MM_ARB_TIMEOUT_EN
  assign o_err      = err_q;
`endif

endmodule

// File: tb/tb_mm_arbiter.sv
// Self-checking bench for mm_arbiter with a behavioural Montgomery core stub
// (modulus 1009, R = 19, fixed latency). Define MM_ARB_TIMEOUT_EN to also cover
// the watchdog with TIMEOUT_CYC = 16.
module tb_mm_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = 255;
  localparam int unsigned LAT = 4;
`ifdef MM_ARB_TIMEOUT_EN
  localparam int unsigned TO  = 16;
`else
  localparam int unsigned TO  = 1024;
`endif

  typedef struct {
    logic [N-1:0] owner;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus, b_bus;
  logic [N-1:0]   grant, done;
  logic [W-1:0]   result, mm_a, mm_b, mm_result;
  logic           busy, mm_start, mm_finished;
  logic           err;

  logic           core_act, core_fin, core_dead, spur_fin;
  int             core_cnt;
  logic [W-1:0]   core_res;

  exp_t           sb[$];
  logic [N-1:0]   grant_log[$];
  int             total, bad, cyc, last_fin, last_done;
  bit             gap_chk;

  mm_arbiter #(
    .N_REQ      (N),
    .W          (W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_a          (a_bus),
    .i_b          (b_bus),
    .o_grant      (grant),
    .o_done       (done),
    .o_result     (result),
    .o_busy       (busy),
    .o_mm_start   (mm_start),
    .o_mm_a       (mm_a),
    .o_mm_b       (mm_b),
`ifdef MM_ARB_TIMEOUT_EN
    .o_err        (err),
`endif
    .i_mm_result  (mm_result),
    .i_mm_finished(mm_finished)
  );

`ifndef MM_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a*b*R^-1 mod 1009 with R = 19 (19^-1 mod 1009 = 478)
  function automatic logic [W-1:0] mm_model(input logic [W-1:0] a, input logic [W-1:0] b);
    return ((((a % W'(1009)) * (b % W'(1009))) % W'(1009)) * W'(478)) % W'(1009);
  endfunction

  always @(posedge clk) begin
    core_fin <= 1'b0;
    if (rst) begin
      core_act <= 1'b0;
      core_cnt <= 0;
    end else if (mm_start) begin
      core_act <= 1'b1;
      core_cnt <= LAT;
      core_res <= mm_model(mm_a, mm_b);
    end else if (core_act && !core_dead) begin
      if (core_cnt == 1) begin
        core_act <= 1'b0;
        core_fin <= 1'b1;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  assign mm_finished = core_fin | spur_fin;
  assign mm_result   = core_res;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event-missing want event", name);
  endtask

  task automatic expect_done(input int idx, input logic [W-1:0] res, input logic e);
    exp_t x;
    x.owner      = '0;
    x.owner[idx] = 1'b1;
    x.res        = res;
    x.err        = e;
    sb.push_back(x);
  endtask

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[k*W +: W] = a;
    b_bus[k*W +: W] = b;
  endtask

  // Advance to the next falling edge and run the scoreboard monitor.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    cyc++;
    if (done != '0) begin
      last_done = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got %0h want 0", done);
      end else begin
        x = sb.pop_front();
        check("done_owner", done, x.owner);
        check("done_result", result, x.res);
        check("done_err", err, x.err);
        check("grant_clear", grant, 0);
        check("busy_clear", busy, 0);
        if (!x.err) check("done_latency", cyc - last_fin, 1);
      end
      req = req & ~done;
    end
    if (mm_finished) last_fin = cyc;
    if (mm_start) begin
      grant_log.push_back(grant);
      if (gap_chk && last_fin >= 0) check("start_gap", cyc - last_fin, 2);
    end
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("done_timeout");
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    grant_log.delete();
    last_fin = -1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[4];
    logic [N-1:0] exp_order[4];
    int           st, re0, re2, n;

    total = 0; bad = 0; cyc = 0; last_fin = -1; last_done = -1;
    gap_chk = 0; core_dead = 0; spur_fin = 0;
    a_bus = '0; b_bus = '0; req = '0; rst = 1'b1;

    vt[0] = '{0, 255'd19,  255'd19, 255'd19};
    vt[1] = '{1, 255'd38,  255'd19, 255'd38};
    vt[2] = '{2, 255'd361, 255'd1,  255'd19};
    vt[3] = '{3, 255'd19,  255'd38, 255'd38};

    // Reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_start", mm_start, 0);
    check("rst_mm_a", mm_a, 0);
    check("rst_mm_b", mm_b, 0);
    check("rst_err", err, 0);

    // 1: single request
    set_op(0, 361, 1);
    expect_done(0, 19, 0);
    req = 4'b0001;
    tick();
    check("t1_start", mm_start, 1);
    check("t1_grant", grant, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_mm_a", mm_a, 361);
    tick();
    check("t1_start_low", mm_start, 0);
    wait_sb(50);

    // 2: all four at once, table driven
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_op(vt[i].idx, vt[i].a, vt[i].b);
      expect_done(vt[i].idx, vt[i].res, 0);
    end
    gap_chk = 1;
    req = 4'b1111;
    wait_sb(200);
    gap_chk = 0;
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() == 0) begin
        fail_now("t2_grant_log");
      end else begin
        check("t2_grant_order", grant_log.pop_front(), 4'(1) << vt[i].idx);
      end
    end

    // 3: fairness, both requesters re-raise once after their done
    do_reset();
    set_op(0, 19, 19);
    set_op(2, 38, 19);
    expect_done(0, 19, 0);
    expect_done(2, 38, 0);
    expect_done(0, 19, 0);
    expect_done(2, 38, 0);
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0100;
    exp_order[2] = 4'b0001; exp_order[3] = 4'b0100;
    req = 4'b0101;
    re0 = 0; re2 = 0; n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
      if (!req[0] && re0 < 1) begin req[0] = 1'b1; re0++; end
      if (!req[2] && re2 < 1) begin req[2] = 1'b1; re2++; end
    end
    if (sb.size() != 0) begin
      fail_now("t3_timeout");
      sb.delete();
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() == 0) fail_now("t3_grant_log");
      else check("t3_grant_order", grant_log.pop_front(), exp_order[i]);
    end

    // 4: owner drops request and changes operand mid-operation
    do_reset();
    set_op(1, 361, 1);
    expect_done(1, 19, 0);
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    set_op(1, 0, 1);
    tick();
    check("t4_held_a", mm_a, 361);
    check("t4_held_b", mm_b, 1);
    wait_sb(50);
    tick();
    spur_fin = 1'b1;
    tick();
    spur_fin = 1'b0;
    tick();
    check("t4_spur_no_done", done, 0);
    check("t4_spur_idle", busy, 0);

    // 5: reset mid-operation
    do_reset();
    set_op(0, 19, 19);
    req = 4'b0001;
    tick();
    check("t5_start", mm_start, 1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_mm_a", mm_a, 0);
    rst = 1'b0;
    req = 4'b0010;
    set_op(1, 38, 19);
    expect_done(1, 38, 0);
    tick();
    check("t5_new_grant", grant, 4'b0010);
    check("t5_new_start", mm_start, 1);
    wait_sb(50);

`ifdef MM_ARB_TIMEOUT_EN
    // 6: watchdog with a core that never finishes
    core_dead = 1'b1;
    do_reset();
    set_op(0, 19, 19);
    expect_done(0, 0, 1);
    req = 4'b0001;
    tick();
    check("t6_start", mm_start, 1);
    st = cyc;
    wait_sb(40);
    check("t6_latency", last_done - st, 17);
    core_dead = 1'b0;
    set_op(1, 38, 19);
    expect_done(1, 38, 0);
    req = 4'b0010;
    wait_sb(50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
